key_enable_pulse: RTL and testbench

//  Upstream stage for the 4-bit up-counter. Takes a raw, bouncy push-button and

---
 rtl/key_pulse_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/key_enable_pulse.sv | 151 +++++++++++++++
 tb/tb_key_enable_pulse.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/key_pulse_pkg.sv
// Shared types and elaboration helpers for the push-button enable-pulse front end.
package key_pulse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESS_DB    = 3'd1,
        ST_HELD_DELAY  = 3'd2,
        ST_HELD_REPEAT = 3'd3,
        ST_RELEASE_DB  = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s0 <= d;
            q  <= s0;
        end
    end

endmodule

// File: rtl/key_enable_pulse.sv
// Debounced push-button to one-cycle enable pulse, with optional auto-repeat while held.
//
// state          | meaning
// ST_IDLE        | button released and debounced, waiting for a synced 1
// ST_PRESS_DB    | counting consecutive synced 1s before accepting the press
// ST_HELD_DELAY  | pressed; counting down the initial repeat delay
// ST_HELD_REPEAT | pressed and repeating; counting down between repeat pulses
// ST_RELEASE_DB  | counting consecutive synced 0s before accepting the release
module key_enable_pulse
    import key_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    input  logic repeat_en,
    output logic enable_out,
    output logic button_state
);

    localparam int DB_W  = clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_DONE    = DB_W'(DEBOUNCE_CYCLES);
    // Timer is a down-counter: a reload of N-1 expires on the N-th edge after the load.
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);

    logic             synced;
    state_t           state, state_nxt;
    logic [DB_W-1:0]  db_cnt, db_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             enable_nxt;
    logic             held_nxt;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (button_in),
        .q     (synced)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            db_cnt       <= '0;
            tmr          <= '0;
            enable_out   <= 1'b0;
            button_state <= 1'b0;
        end else begin
            state        <= state_nxt;
            db_cnt       <= db_nxt;
            tmr          <= tmr_nxt;
            enable_out   <= enable_nxt;
            button_state <= held_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        db_nxt     = db_cnt;
        tmr_nxt    = tmr;
        enable_nxt = 1'b0;
        held_nxt   = button_state;

        case (state)
            ST_IDLE: begin
                held_nxt = 1'b0;
                db_nxt   = '0;
                if (synced) begin
                    state_nxt = ST_PRESS_DB;
                    db_nxt    = DB_ONE;
                end
            end

            ST_PRESS_DB: begin
                held_nxt = 1'b0;
                if (!synced) begin
                    state_nxt = ST_IDLE;
                    db_nxt    = '0;
                end else if (db_cnt == DB_DONE) begin
                    state_nxt  = ST_HELD_DELAY;
                    held_nxt   = 1'b1;
                    enable_nxt = 1'b1;
                    tmr_nxt    = DELAY_LOAD;
                    db_nxt     = '0;
                end else begin
                    db_nxt = db_cnt + DB_ONE;
                end
            end

            // Timer parks at zero while repeat is off, so enabling repeat fires on the next edge.
            ST_HELD_DELAY: begin
                held_nxt = 1'b1;
                if (!synced) begin
                    state_nxt = ST_RELEASE_DB;
                    db_nxt    = DB_ONE;
                end else if (repeat_en && (tmr == '0)) begin
                    state_nxt  = ST_HELD_REPEAT;
                    enable_nxt = 1'b1;
                    tmr_nxt    = RATE_LOAD;
                end else if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end
            end

            ST_HELD_REPEAT: begin
                held_nxt = 1'b1;
                if (!synced) begin
                    state_nxt = ST_RELEASE_DB;
                    db_nxt    = DB_ONE;
                end else if (!repeat_en) begin
                    state_nxt = ST_HELD_DELAY;
                    tmr_nxt   = DELAY_LOAD;
                end else if (tmr == '0) begin
                    enable_nxt = 1'b1;
                    tmr_nxt    = RATE_LOAD;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end

            ST_RELEASE_DB: begin
                held_nxt = 1'b1;
                if (synced) begin
                    state_nxt = ST_HELD_DELAY;
                    tmr_nxt   = DELAY_LOAD;
                    db_nxt    = '0;
                end else if (db_cnt == DB_DONE) begin
                    state_nxt = ST_IDLE;
                    held_nxt  = 1'b0;
                    db_nxt    = '0;
                end else begin
                    db_nxt = db_cnt + DB_ONE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                held_nxt  = 1'b0;
                db_nxt    = '0;
                tmr_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_enable_pulse.sv
// Directed bench for key_enable_pulse with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3.
module tb_key_enable_pulse;

    logic clock;
    logic reset;
    logic button_in;
    logic repeat_en;
    logic enable_out;
    logic button_state;

    int vectors;
    int miscompares;

    key_enable_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_RATE     (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_in    (button_in),
        .repeat_en    (repeat_en),
        .enable_out   (enable_out),
        .button_state (button_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic observed, input logic expected);
        vectors = vectors + 1;
        assert (observed === expected)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        button_in   = 1'b0;
        repeat_en   = 1'b0;

        // Reset state
        tick(); tick();
        chk("reset enable_out", enable_out, 1'b0);
        chk("reset button_state", button_state, 1'b0);
        #2 reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("idle en[%0d]", i), enable_out, 1'b0);
        end

        // 1: clean press, first sampled at tick 1, pulse at tick 1+2+4
        button_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk($sformatf("t1 en[%0d]", i), enable_out, (i == 7));
            chk($sformatf("t1 st[%0d]", i), button_state, (i >= 7));
        end

        // 3: release with a 2-cycle glitch of 1 after three 0 samples
        for (int i = 1; i <= 20; i++) begin
            button_in = (i == 4 || i == 5);
            tick();
            chk($sformatf("t3 en[%0d]", i), enable_out, 1'b0);
            chk($sformatf("t3 st[%0d]", i), button_state, (i <= 11));
        end

        // 2: press bounce 1,1,1,0 then stable 1
        for (int i = 1; i <= 15; i++) begin
            button_in = (i != 4);
            tick();
            chk($sformatf("t2 en[%0d]", i), enable_out, (i == 11));
            chk($sformatf("t2 st[%0d]", i), button_state, (i >= 11));
        end
        button_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t2r en[%0d]", i), enable_out, 1'b0);
            chk($sformatf("t2r st[%0d]", i), button_state, (i <= 6));
        end

        // 4: auto-repeat, press pulse at tick 7, repeats at 15, 18, 21, 24
        repeat_en = 1'b1;
        button_in = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            chk($sformatf("t4 en[%0d]", i), enable_out,
                (i == 7) || (i >= 15 && ((i - 15) % 3) == 0));
            chk($sformatf("t4 st[%0d]", i), button_state, (i >= 7));
        end
        // a repeat was due on the next edge; dropping repeat_en suppresses it
        repeat_en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t4 off en[%0d]", i), enable_out, 1'b0);
            chk($sformatf("t4 off st[%0d]", i), button_state, 1'b1);
        end
        // delay timer has expired, so re-enabling repeat pulses on the next edge
        repeat_en = 1'b1;
        tick();
        chk("t4 re-enable pulse", enable_out, 1'b1);

        // 5: asynchronous reset between edges while in HELD_REPEAT
        #2 reset = 1'b1;
        #1;
        chk("t5 async en", enable_out, 1'b0);
        chk("t5 async st", button_state, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #4 reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t5 en[%0d]", i), enable_out, (i == 7));
            chk($sformatf("t5 st[%0d]", i), button_state, (i >= 7));
        end
        repeat_en = 1'b0;
        button_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t5r en[%0d]", i), enable_out, 1'b0);
            chk($sformatf("t5r st[%0d]", i), button_state, (i <= 6));
        end

        // 6: single-cycle glitches every 3 cycles never qualify
        for (int i = 0; i < 51; i++) begin
            button_in = ((i % 3) == 0);
            tick();
            chk($sformatf("t6 en[%0d]", i), enable_out, 1'b0);
            chk($sformatf("t6 st[%0d]", i), button_state, 1'b0);
        end
        button_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
